// File: rtl/k2_order_bank_mapper_pkg.sv
// Shared NTT memory definitions: bank count, address-to-bank hash, control states.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ntt_pkg;

  localparam int BANK_BITS   = 4;    // 16 banks
  localparam int ADDR_MAX    = 32;   // widest address bank_of() accepts
  localparam int D_WIDTH_DEF = 12;   // default coefficient address width
  localparam int RADIX_K1    = 1;
  localparam int K_STAGES    = 5;
  localparam int NUM_BEATS_DEF = (1 << (RADIX_K1 * K_STAGES)) / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  // Bank = sum of all BANK_BITS-wide digits, wrapped to BANK_BITS bits. The
  // address is zero-extended, so the extra high digits contribute nothing and
  // the result equals the sum of the D_WIDTH/BANK_BITS digits of the real
  // address (D_WIDTH is expected to be a multiple of BANK_BITS).
  function automatic logic [BANK_BITS-1:0] bank_of(input logic [ADDR_MAX-1:0] addr);
    logic [BANK_BITS-1:0] sum;
    sum = '0;
    for (int i = 0; i < ADDR_MAX / BANK_BITS; i++) begin
      sum = sum + addr[i*BANK_BITS +: BANK_BITS];
    end
    return sum;
  endfunction

endpackage

// File: rtl/k2_order_bank_mapper_fifo.sv
// Beat FIFO: stores one mapped beat per entry; head shown combinationally.
// Latency: a write at edge t is visible at the head from t+1.
// Backpressure: write refused when full unless a read happens the same cycle.
// Ports: clk/rst, wr_en/wr_data, rd_en, rd_data (zero when empty), full, empty.
module beat_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4    // power of 2, at least 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             rd_ok, wr_ok;

  // Extra pointer bit separates full from empty when the indices coincide.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  // Head is forced to zero when empty so outputs read as zero after reset.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/k2_order_bank_mapper.sv
// Maps k2 AGU address beats to {bank,row} per lane and queues them for the banked SRAM.
// Latency: capture edge t -> out_valid with head data at t+1; errors at t+1.
// Backpressure: out_ready stalls the FIFO head; a capture into a full FIFO is dropped.
// Ports: in_valid/in_done/in_addr from the AGU; out_valid/out_ready/out_bank/out_row
//        to memory; pass_done pulse; sticky conflict_err and overflow_err.
module k2_order_bank_mapper
  import ntt_pkg::*;
#(
  parameter int D_WIDTH    = D_WIDTH_DEF,
  parameter int LANES      = 16,
  parameter int BANK_BITS  = ntt_pkg::BANK_BITS,
  parameter int HOLD       = 2,
  parameter int NUM_BEATS  = NUM_BEATS_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  logic                               in_done,
  input  logic [LANES*D_WIDTH-1:0]           in_addr,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [LANES*BANK_BITS-1:0]         out_bank,
  output logic [LANES*(D_WIDTH-BANK_BITS)-1:0] out_row,
  output logic                               pass_done,
  output logic                               conflict_err,
  output logic                               overflow_err
);

  localparam int ROW_W   = D_WIDTH - BANK_BITS;
  localparam int ENTRY_W = LANES * D_WIDTH;
  localparam int PH_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int BC_W    = $clog2(NUM_BEATS + 1);

  logic [PH_W-1:0]      ph;
  logic [BC_W-1:0]      beat_cnt;
  logic                 capture;
  logic [BANK_BITS-1:0] lane_bank [LANES];
  logic [ROW_W-1:0]     lane_row  [LANES];
  logic                 conflict;
  logic [ENTRY_W-1:0]   wr_entry, head;
  logic                 fifo_full, fifo_empty, rd_en;
  logic                 in_done_q, done_rise, done_pend;
  state_t               state, state_n;

  // Capture on the last cycle of each hold window, where the AGU's registered
  // output has settled; groups beyond NUM_BEATS in a pass are ignored.
  assign capture = in_valid && (ph == PH_W'(HOLD - 1)) && (beat_cnt < BC_W'(NUM_BEATS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph       <= '0;
      beat_cnt <= '0;
    end else begin
      if (!in_valid || ph == PH_W'(HOLD - 1)) ph <= '0;
      else                                    ph <= ph + 1'b1;
      if (!in_valid || pass_done) beat_cnt <= '0;
      else if (capture)           beat_cnt <= beat_cnt + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_bank[i] = bank_of(ADDR_MAX'(in_addr[i*D_WIDTH +: D_WIDTH]));
      lane_row[i]  = in_addr[i*D_WIDTH + BANK_BITS +: ROW_W];
    end
  end

  // Any two lanes of one beat landing on the same bank.
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (lane_bank[i] == lane_bank[j]) conflict = 1'b1;
      end
    end
  end

  // Entry layout: banks in the upper LANES*BANK_BITS bits, rows below.
  always_comb begin
    wr_entry = '0;
    for (int i = 0; i < LANES; i++) begin
      wr_entry[LANES*ROW_W + i*BANK_BITS +: BANK_BITS] = lane_bank[i];
      wr_entry[i*ROW_W +: ROW_W]                       = lane_row[i];
    end
  end

  assign out_valid = !fifo_empty;
  assign rd_en     = out_valid && out_ready;
  assign out_bank  = head[ENTRY_W-1 -: LANES*BANK_BITS];
  assign out_row   = head[LANES*ROW_W-1:0];

  beat_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (capture),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Done is held pending until every queued beat has left, so a beat captured
  // alongside in_done still drains before pass_done.
  assign done_rise = in_done && !in_done_q;
  assign pass_done = done_pend && fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_done_q    <= 1'b0;
      done_pend    <= 1'b0;
      conflict_err <= 1'b0;
      overflow_err <= 1'b0;
      state        <= IDLE;
    end else begin
      in_done_q    <= in_done;
      done_pend    <= (done_pend && !pass_done) || done_rise;
      conflict_err <= conflict_err || (capture && conflict);
      overflow_err <= overflow_err || (capture && fifo_full && !rd_en);
      state        <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = COLLECT;
      COLLECT: if (done_rise) state_n = FLUSH;
               else if (!in_valid) state_n = IDLE;
      FLUSH:   if (fifo_empty) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_k2_order_bank_mapper.sv
// Directed bench for k2_order_bank_mapper with a queue-based reference model.
// Latency: n/a.
// Backpressure: out_ready driven directly by the stimulus.
module tb_k2_order_bank_mapper;

  localparam int D = 12, L = 16, BB = 4, HOLD = 2, NB = 4, DEPTH = 4;
  localparam int RW = D - BB;

  logic              clk = 1'b0;
  logic              rst, in_valid, in_done, out_ready, out_valid;
  logic [L*D-1:0]    in_addr;
  logic [L*BB-1:0]   out_bank;
  logic [L*RW-1:0]   out_row;
  logic              pass_done, conflict_err, overflow_err;

  k2_order_bank_mapper #(
    .D_WIDTH(D), .LANES(L), .BANK_BITS(BB), .HOLD(HOLD), .NUM_BEATS(NB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_done(in_done), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_bank(out_bank), .out_row(out_row),
    .pass_done(pass_done), .conflict_err(conflict_err), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [L*BB-1:0] b; logic [L*RW-1:0] r; } ent_t;
  ent_t mq[$];
  logic model_cap;          // stimulus marks the cycle where a capture must occur
  logic m_conf, m_ovf, m_done_pend, m_done_q;
  logic m_pop, m_full, m_was_empty;
  ent_t m_e;
  int   m_banks [L];

  function automatic int digit_bank(input int a);
    int s = 0;
    int x = a;
    while (x > 0) begin
      s = s + (x % 16);
      x = x / 16;
    end
    return s % 16;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_conf = 0; m_ovf = 0; m_done_pend = 0; m_done_q = 0;
    end else begin
      m_was_empty = (mq.size() == 0);
      m_pop  = !m_was_empty && out_ready;
      m_full = (mq.size() >= DEPTH);
      if (m_pop) void'(mq.pop_front());
      if (model_cap) begin
        for (int i = 0; i < L; i++) begin
          int a;
          a = int'(in_addr[i*D +: D]);
          m_banks[i] = digit_bank(a);
          m_e.b[i*BB +: BB] = 4'(m_banks[i]);
          m_e.r[i*RW +: RW] = 8'(a / 16);
        end
        for (int i = 0; i < L; i++)
          for (int j = i + 1; j < L; j++)
            if (m_banks[i] == m_banks[j]) m_conf = 1;
        if (!m_full || m_pop) mq.push_back(m_e);
        else m_ovf = 1;
      end
      m_done_pend = (m_done_pend && !(m_was_empty && m_done_pend)) || (in_done && !m_done_q);
      m_done_q = in_done;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        check("out_bank", out_bank, mq[0].b);
        check("out_row", out_row, mq[0].r);
      end
      check("pass_done", pass_done, m_done_pend && mq.size() == 0);
      check("conflict_err", conflict_err, m_conf);
      check("overflow_err", overflow_err, m_ovf);
    end
  end

  int xfer_cnt = 0, pd_cnt = 0;
  always @(posedge clk) begin
    if (out_valid && out_ready) xfer_cnt++;
    if (pass_done) pd_cnt++;
  end

  // ---------------- stimulus ----------------
  int grp = 0;

  function automatic logic [L*D-1:0] beat(input int base);
    logic [L*D-1:0] v;
    for (int i = 0; i < L; i++) v[i*D +: D] = 12'(base + i);
    return v;
  endfunction

  task automatic send_group(input logic [L*D-1:0] v, input bit rdy_last, input bit done_last);
    logic saved_rdy;
    saved_rdy = out_ready;
    for (int h = 0; h < HOLD; h++) begin
      in_valid  = 1'b1;
      in_addr   = v;
      model_cap = (h == HOLD - 1) && (grp < NB);
      if (h == HOLD - 1 && rdy_last)  out_ready = 1'b1;
      if (h == HOLD - 1 && done_last) in_done = 1'b1;
      @(posedge clk); #1;
    end
    model_cap = 1'b0;
    out_ready = saved_rdy;
    in_done   = 1'b0;
    grp++;
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    model_cap = 1'b0;
    grp = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_done();
    in_done = 1'b1;
    @(posedge clk); #1;
    in_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [L*D-1:0] cv;
  int x0, p0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 0; in_done = 0; in_addr = '0; out_ready = 1; model_cap = 0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bank", out_bank, 0);
    check("rst_out_row", out_row, 0);
    check("rst_pass_done", pass_done, 0);
    check("rst_conflict", conflict_err, 0);
    check("rst_overflow", overflow_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // 1: single beat of 0..15, capture on second cycle, one-cycle out_valid
    in_valid = 1; in_addr = beat(0); model_cap = 0;
    @(posedge clk); #1;
    check("t1_no_early_valid", out_valid, 0);
    model_cap = 1;
    @(posedge clk); #1;
    model_cap = 0; in_valid = 0;
    check("t1_valid", out_valid, 1);
    check("t1_banks", out_bank, 64'hFEDCBA9876543210);
    check("t1_rows", out_row, 0);
    @(posedge clk); #1;
    check("t1_valid_one_cycle", out_valid, 0);
    check("t1_no_conflict", conflict_err, 0);
    idle(2);

    // 2: NB+1 groups then in_done -> NB writes, single pass_done
    x0 = xfer_cnt; p0 = pd_cnt;
    for (int k = 0; k < NB + 1; k++) send_group(beat(k * 16), 0, 0);
    idle(1);
    pulse_done();
    idle(6);
    check("t2_xfers", xfer_cnt - x0, NB);
    check("t2_pass_done", pd_cnt - p0, 1);

    // 2b: in_done on the last capture -> beat drained before pass_done
    x0 = xfer_cnt; p0 = pd_cnt;
    send_group(beat(12'h400), 0, 0);
    send_group(beat(12'h410), 0, 1);
    idle(6);
    check("t2b_xfers", xfer_cnt - x0, 2);
    check("t2b_pass_done", pd_cnt - p0, 1);

    // 3: lanes 0 and 1 both hit bank 1
    cv = beat(0);
    cv[0 +: D] = 12'h001;
    cv[D +: D] = 12'h010;
    send_group(cv, 0, 0);
    check("t3_conflict", conflict_err, 1);
    idle(4);
    check("t3_conflict_sticky", conflict_err, 1);
    do_reset();
    check("t3_conflict_cleared", conflict_err, 0);
    idle(1);

    // 4: five captures with out_ready low -> 4 held, overflow, drain in order
    out_ready = 0;
    for (int k = 0; k < 3; k++) send_group(beat(12'h200 + k * 16), 0, 0);
    idle(1);
    for (int k = 3; k < 5; k++) send_group(beat(12'h200 + k * 16), 0, 0);
    check("t4_overflow", overflow_err, 1);
    x0 = xfer_cnt;
    out_ready = 1;
    idle(8);
    check("t4_drained", xfer_cnt - x0, 4);
    do_reset();
    idle(1);

    // 5: capture into full FIFO while reading -> no overflow, occupancy stays 4
    out_ready = 0;
    for (int k = 0; k < 2; k++) send_group(beat(12'h500 + k * 16), 0, 0);
    idle(1);
    for (int k = 2; k < 4; k++) send_group(beat(12'h500 + k * 16), 0, 0);
    idle(1);
    send_group(beat(12'h580), 1, 0);
    check("t5_no_overflow", overflow_err, 0);
    idle(2);
    x0 = xfer_cnt;
    out_ready = 1;
    idle(8);
    check("t5_occupancy", xfer_cnt - x0, 4);

    // 6: reset during FLUSH with 2 entries queued
    out_ready = 0;
    for (int k = 0; k < 2; k++) send_group(beat(12'h600 + k * 16), 0, 0);
    idle(1);
    pulse_done();
    idle(2);
    p0 = pd_cnt;
    rst = 1'b1;
    #1;
    check("t6_valid_async", out_valid, 0);
    check("t6_pd_async", pass_done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_no_pass_done", pd_cnt - p0, 0);
    out_ready = 1;
    x0 = xfer_cnt;
    send_group(beat(12'h700), 0, 0);
    idle(2);
    pulse_done();
    idle(5);
    check("t6_new_pass_xfer", xfer_cnt - x0, 1);
    check("t6_new_pass_done", pd_cnt - p0, 1);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
